csr_wr_ctrl: RTL and testbench

Sequencing block directly upstream of a single CSR storage register. Accepts one CSR instruction at a time over a valid/ready handshake, reads the current register value, computes the read-modify-write result for CSRRW/CSRRS/CSRRC (register and immediate forms), and applies the read-only and WPRI bit masks. It then drives the next-value bus into the CSR flop bank. On every cycle when no write is committing, it holds the bus at the current value. The old value is returned to the pipeline for writeback to rd.

---
 rtl/csr_wr_ctrl.sv | 156 +++++++++++++++
 tb/tb_csr_wr_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_wr_ctrl.sv
// -----------------------------------------------------------------------------
// csr_wr_ctrl
//
// Read-modify-write sequencer that sits in front of a single CSR flop bank.
// It takes one CSR instruction at a time, captures the current register value,
// computes the CSRRW/CSRRS/CSRRC result (register and immediate forms), and
// protects read-only and WPRI bits. During the commit cycle it drives the new
// value onto csr_data. In every other cycle csr_data is csr_name, so the
// downstream flop simply reloads its own value.
//
// Parameters:
//   SZ        CSR width
//   RO_BITS   bits fixed by build configuration, never changed by a write
//   WPRI_BITS reserved bits, never changed by a write
//   CSR_RO    1 = whole CSR is read-only; any real write attempt is illegal
//
// Ports:
//   clk_in, reset_in        clock, synchronous active-high reset
//   req_valid / req_ready   request handshake
//   req_funct3              001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   req_src                 rs1 value or zero-extended uimm
//   req_src_is_zero         rs1 is x0 / uimm is zero
//   flush                   kill of the in-flight request (ignored in COMMIT)
//   csr_name                current CSR register value
//   csr_data                next value for the CSR register
//   rsp_valid               one-cycle response strobe
//   rsp_rdata               CSR value before the instruction
//   rsp_illegal, rsp_wrote  response flags, qualified by rsp_valid
// -----------------------------------------------------------------------------
module csr_wr_ctrl #(
   parameter int            SZ        = 32,
   parameter logic [SZ-1:0] RO_BITS   = '0,
   parameter logic [SZ-1:0] WPRI_BITS = '0,
   parameter bit            CSR_RO    = 1'b0
) (
   input  logic          clk_in,
   input  logic          reset_in,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [2:0]    req_funct3,
   input  logic [SZ-1:0] req_src,
   input  logic          req_src_is_zero,
   input  logic          flush,
   input  logic [SZ-1:0] csr_name,
   output logic [SZ-1:0] csr_data,
   output logic          rsp_valid,
   output logic [SZ-1:0] rsp_rdata,
   output logic          rsp_illegal,
   output logic          rsp_wrote
);

   // Bits a write is allowed to change.
   localparam logic [SZ-1:0] WMASK = ~(RO_BITS | WPRI_BITS);

   typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

   state_t        state;
   logic [2:0]    funct3_q;
   logic [SZ-1:0] src_q;
   logic          src_zero_q;
   logic [SZ-1:0] old_q;
   logic [SZ-1:0] wr_val;

   logic          accept;
   logic [SZ-1:0] raw;
   logic          do_write;
   logic          illegal;

   assign req_ready = (state == IDLE) && !reset_in;
   assign accept    = req_valid && req_ready && !flush;

   // Reset is sampled synchronously, so the state is still COMMIT during a
   // reset cycle; gating here keeps a reset from letting a write through.
   assign csr_data = (state == COMMIT && rsp_wrote && !reset_in) ? wr_val : csr_name;

   // Operation decode and raw read-modify-write result.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      raw      = src_q;
      do_write = 1'b0;
      illegal  = 1'b0;
      case (funct3_q)
         3'b001, 3'b101: begin
            raw      = src_q;
            do_write = 1'b1;
         end
         3'b010, 3'b110: begin
            raw      = old_q | src_q;
            do_write = !src_zero_q;
         end
         3'b011, 3'b111: begin
            raw      = old_q & ~src_q;
            do_write = !src_zero_q;
         end
         default: illegal = 1'b1;
      endcase
      if (CSR_RO && do_write) illegal = 1'b1;
   end

   // Request capture. These are pure datapath holding registers, only read
   // after being loaded by an accepted request.
   // NOTE: datapath registers without a functional reset value are left out
   // of the reset branch; only control state and visible outputs are reset.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         funct3_q   <= req_funct3;
         src_q      <= req_src;
         src_zero_q <= req_src_is_zero;
         old_q      <= csr_name;
      end
   end

   // Sequencing FSM with registered response outputs.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state       <= IDLE;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_illegal <= 1'b0;
         rsp_wrote   <= 1'b0;
         wr_val      <= '0;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               if (accept) state <= CALC;
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  wr_val      <= (raw & WMASK) | (old_q & ~WMASK);
                  rsp_rdata   <= old_q;
                  rsp_illegal <= illegal;
                  rsp_wrote   <= do_write && !illegal;
                  rsp_valid   <= 1'b1;
                  state       <= COMMIT;
               end
            end
            COMMIT: begin
               // Commit point: flush no longer has any effect here.
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_wr_ctrl
//
// Four csr_wr_ctrl instances with different mask/read-only configurations
// share one request stream. Each instance drives its own CSR register model,
// and a behavioural per-bit reference computes the expected response and new
// value for every request.
// -----------------------------------------------------------------------------
module tb_csr_wr_ctrl;

   localparam int N = 4;
   // Instance configurations, index 0 is the rightmost entry.
   localparam logic [N-1:0][31:0] RO_P   = {32'h8000_0001, 32'h0, 32'h0000_000F, 32'h0};
   localparam logic [N-1:0][31:0] WPRI_P = {32'h0000_FF00, 32'h0, 32'h0,         32'h0};
   localparam logic [N-1:0]       CRO_P  = 4'b0100;

   // Operating modes for one request.
   localparam int M_FLUSH_IDLE   = 0;
   localparam int M_FLUSH_CALC   = 1;
   localparam int M_FLUSH_COMMIT = 2;
   localparam int M_RESET_CALC   = 3;
   localparam int M_NORMAL       = 4;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        req_valid;
   logic [2:0]  req_funct3;
   logic [31:0] req_src;
   logic        req_src_is_zero;
   logic        flush;
   logic        preload_en;
   logic [31:0] preload_val;

   logic        req_ready   [N];
   logic        rsp_valid   [N];
   logic        rsp_illegal [N];
   logic        rsp_wrote   [N];
   logic [31:0] rsp_rdata   [N];
   logic [31:0] csr_data    [N];
   logic [31:0] csr_reg     [N];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_in = ~clk_in;

   for (genvar g = 0; g < N; g++) begin : g_dut
      csr_wr_ctrl #(
         .SZ        (32),
         .RO_BITS   (RO_P[g]),
         .WPRI_BITS (WPRI_P[g]),
         .CSR_RO    (CRO_P[g])
      ) u_dut (
         .clk_in          (clk_in),
         .reset_in        (reset_in),
         .req_valid       (req_valid),
         .req_ready       (req_ready[g]),
         .req_funct3      (req_funct3),
         .req_src         (req_src),
         .req_src_is_zero (req_src_is_zero),
         .flush           (flush),
         .csr_name        (csr_reg[g]),
         .csr_data        (csr_data[g]),
         .rsp_valid       (rsp_valid[g]),
         .rsp_rdata       (rsp_rdata[g]),
         .rsp_illegal     (rsp_illegal[g]),
         .rsp_wrote       (rsp_wrote[g])
      );

      // The CSR flop bank fed by csr_data; preload lets the bench set values.
      always @(posedge clk_in) csr_reg[g] <= preload_en ? preload_val : csr_data[g];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: what the CSR instruction means architecturally, bit by bit.
   function automatic void model(input logic [2:0] f3, input logic [31:0] src,
                                 input bit zero, input logic [31:0] old,
                                 input logic [31:0] keep, input bit cro,
                                 output logic [31:0] nv, output bit ill, output bit wr);
      logic [31:0] tgt;
      bit          attempt;
      ill     = 1'b0;
      attempt = 1'b0;
      tgt     = old;
      case (f3)
         3'd1, 3'd5: begin attempt = 1'b1;  tgt = src;        end
         3'd2, 3'd6: begin attempt = !zero; tgt = old | src;  end
         3'd3, 3'd7: begin attempt = !zero; tgt = old & ~src; end
         default:    ill = 1'b1;
      endcase
      if (cro && attempt) ill = 1'b1;
      wr = attempt && !ill;
      for (int i = 0; i < 32; i++) nv[i] = (wr && !keep[i]) ? tgt[i] : old[i];
   endfunction

   task automatic preload(input logic [31:0] v);
      @(negedge clk_in);
      preload_en  = 1'b1;
      preload_val = v;
      @(negedge clk_in);
      preload_en  = 1'b0;
   endtask

   // Junk on the request inputs while the block is busy; it must be ignored.
   task automatic noise();
      req_valid       = 1'($urandom);
      req_funct3      = 3'($urandom);
      req_src         = $urandom;
      req_src_is_zero = 1'($urandom);
   endtask

   task automatic run(input logic [2:0] f3, input logic [31:0] src, input bit zero, input int mode);
      logic [31:0] old [N];
      logic [31:0] nv  [N];
      bit          ill [N];
      bit          wr  [N];

      @(negedge clk_in);
      for (int k = 0; k < N; k++) begin
         old[k] = csr_reg[k];
         model(f3, src, zero, old[k], RO_P[k] | WPRI_P[k], CRO_P[k], nv[k], ill[k], wr[k]);
         check($sformatf("idle_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
      end
      req_valid       = 1'b1;
      req_funct3      = f3;
      req_src         = src;
      req_src_is_zero = zero;
      flush           = (mode == M_FLUSH_IDLE);

      @(negedge clk_in);
      flush = 1'b0;
      if (mode == M_FLUSH_IDLE) begin
         req_valid = 1'b0;
         for (int k = 0; k < N; k++) begin
            check($sformatf("drop_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
            check($sformatf("drop_rsp[%0d]", k), 32'(rsp_valid[k]), 32'd0);
         end
         return;
      end
      noise();
      for (int k = 0; k < N; k++) begin
         check($sformatf("calc_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
         check($sformatf("calc_rsp[%0d]", k), 32'(rsp_valid[k]), 32'd0);
         check($sformatf("calc_hold[%0d]", k), csr_data[k], old[k]);
      end
      flush    = (mode == M_FLUSH_CALC);
      reset_in = (mode == M_RESET_CALC);

      @(negedge clk_in);
      flush = 1'b0;
      if (mode == M_FLUSH_CALC) begin
         req_valid = 1'b0;
         for (int k = 0; k < N; k++) begin
            check($sformatf("fl_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
            check($sformatf("fl_rsp[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("fl_csr[%0d]", k), csr_reg[k], old[k]);
         end
         return;
      end
      if (mode == M_RESET_CALC) begin
         req_valid = 1'b0;
         for (int k = 0; k < N; k++) begin
            check($sformatf("rst_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
            check($sformatf("rst_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("rst_rdata[%0d]", k), rsp_rdata[k], 32'd0);
            check($sformatf("rst_ill[%0d]", k), 32'(rsp_illegal[k]), 32'd0);
            check($sformatf("rst_wrote[%0d]", k), 32'(rsp_wrote[k]), 32'd0);
            check($sformatf("rst_csr[%0d]", k), csr_reg[k], old[k]);
            check($sformatf("rst_data[%0d]", k), csr_data[k], old[k]);
         end
         reset_in = 1'b0;
         #1;
         for (int k = 0; k < N; k++)
            check($sformatf("rst_ready_rel[%0d]", k), 32'(req_ready[k]), 32'd1);
         return;
      end
      noise();
      flush = (mode == M_FLUSH_COMMIT);
      for (int k = 0; k < N; k++) begin
         check($sformatf("cm_valid[%0d]", k), 32'(rsp_valid[k]), 32'd1);
         check($sformatf("cm_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
         check($sformatf("cm_rdata[%0d]", k), rsp_rdata[k], old[k]);
         check($sformatf("cm_ill[%0d]", k), 32'(rsp_illegal[k]), 32'(ill[k]));
         check($sformatf("cm_wrote[%0d]", k), 32'(rsp_wrote[k]), 32'(wr[k]));
         check($sformatf("cm_data[%0d]", k), csr_data[k], nv[k]);
      end

      @(negedge clk_in);
      flush     = 1'b0;
      req_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         check($sformatf("new_csr[%0d]", k), csr_reg[k], nv[k]);
         check($sformatf("post_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
         check($sformatf("post_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
      end
   endtask

   initial begin
      reset_in        = 1'b1;
      req_valid       = 1'b0;
      req_funct3      = 3'd0;
      req_src         = '0;
      req_src_is_zero = 1'b0;
      flush           = 1'b0;
      preload_en      = 1'b1;
      preload_val     = 32'h0000_00F0;

      // Reset: not ready, bus follows csr_name.
      repeat (3) @(negedge clk_in);
      preload_en = 1'b0;
      for (int k = 0; k < N; k++) begin
         check($sformatf("reset_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
         check($sformatf("reset_data[%0d]", k), csr_data[k], 32'h0000_00F0);
      end
      reset_in = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("init_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
         check($sformatf("init_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
         check($sformatf("init_rdata[%0d]", k), rsp_rdata[k], 32'd0);
         check($sformatf("init_ill[%0d]", k), 32'(rsp_illegal[k]), 32'd0);
         check($sformatf("init_wrote[%0d]", k), 32'(rsp_wrote[k]), 32'd0);
      end

      // Directed cases.
      run(3'b001, 32'h1234_5678, 1'b0, M_NORMAL);          // RW
      preload(32'hA5A5_A5A5);
      run(3'b010, 32'h0000_0000, 1'b1, M_NORMAL);          // RS from x0
      preload(32'hFFFF_FFFF);
      run(3'b011, 32'hFFFF_FFFF, 1'b0, M_NORMAL);          // RC, RO bits kept
      run(3'b101, 32'h0000_0005, 1'b0, M_NORMAL);          // RWI (illegal on RO CSR)
      run(3'b110, 32'h0000_0000, 1'b1, M_NORMAL);          // RSI uimm 0
      run(3'b001, 32'h0BAD_F00D, 1'b0, M_FLUSH_CALC);
      run(3'b001, 32'h600D_CAFE, 1'b0, M_FLUSH_COMMIT);
      run(3'b011, 32'h0000_FFFF, 1'b0, M_RESET_CALC);
      run(3'b100, 32'h1111_1111, 1'b0, M_NORMAL);          // illegal funct3
      run(3'b000, 32'h2222_2222, 1'b0, M_NORMAL);          // illegal funct3
      run(3'b001, 32'h3333_3333, 1'b0, M_FLUSH_IDLE);      // dropped request

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         logic [2:0]  f3;
         logic [31:0] src;
         bit          zero;
         int          mode;
         if ($urandom_range(0, 5) == 0) preload($urandom);
         f3   = 3'($urandom);
         zero = ($urandom_range(0, 3) == 0);
         src  = zero ? 32'd0 : $urandom;
         case ($urandom_range(0, 9))
            0:       mode = M_FLUSH_IDLE;
            1:       mode = M_FLUSH_CALC;
            2:       mode = M_FLUSH_COMMIT;
            3:       mode = M_RESET_CALC;
            default: mode = M_NORMAL;
         endcase
         run(f3, src, zero, mode);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
